// File: rtl/apb_sram_pkg.sv
// Shared types and helpers for the APB SRAM slave.
// Optional byte-strobe writes are enabled by defining APB_SRAM_STRB_EN.
package apb_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } apb_sram_state_t;

  localparam int MAX_WAIT_STATES = 15;

  // Byte-lane offset: number of low address bits that select a byte inside a word.
  function automatic int calc_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_sram_slave_if.sv
// APB bus bundle between master and the SRAM slave.
// The pstrb signal exists only when APB_SRAM_STRB_EN is defined.
interface apb_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   paddr;
  logic                wr_en;
  logic                psel;
  logic                pen;
  logic [DATA_W-1:0]   pwdata;
`ifdef APB_SRAM_STRB_EN
  logic [DATA_W/8-1:0] pstrb;
`endif
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pselverr;

  modport master (
    output paddr, wr_en, psel, pen, pwdata,
`ifdef APB_SRAM_STRB_EN
    output pstrb,
`endif
    input  prdata, pready, pselverr
  );

  modport slave (
    input  paddr, wr_en, psel, pen, pwdata,
`ifdef APB_SRAM_STRB_EN
    input  pstrb,
`endif
    output prdata, pready, pselverr
  );
endinterface

// File: rtl/apb_sram_mem.sv
// DEPTH x DATA_W storage: combinational read, synchronous byte-enabled write.
module apb_sram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto SRAM macros; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_sram_slave.sv
// APB slave fronting a single-port SRAM with configurable wait states and error response.
// Define APB_SRAM_STRB_EN to enable per-byte write strobes (pstrb).
module apb_sram_slave
  import apb_sram_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             rst,
  apb_sram_slave_if.slave  bus
);
  localparam int LSB  = calc_lsb(DATA_W);
  localparam int NB   = DATA_W / 8;
  localparam int AW   = addr_bits(DEPTH);
  localparam int WS_I = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam logic [3:0]        WS_LOAD    = 4'(WS_I);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);

  apb_sram_state_t   state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     strb_q, strb_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pselverr_q, pselverr_d;

  logic [ADDR_W-1:0] idx;
  logic              setup_err;
  logic              setup;
  logic              complete;
  logic              mem_we;
  logic [AW-1:0]     rd_addr;
  logic              rd_err;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    idx       = bus.paddr >> LSB;
    setup_err = (idx >= DEPTH_A) || ((bus.paddr & ALIGN_MASK) != '0);
    setup     = bus.psel && !bus.pen;
    complete  = (state_q == ST_ACCESS) && bus.psel && bus.pen;
    mem_we    = complete && wr_q && !err_q;
    // With zero wait states the read data is captured on the setup edge itself.
    rd_addr   = (state_q == ST_IDLE) ? idx[AW-1:0] : addr_q;
    rd_err    = (state_q == ST_IDLE) ? setup_err   : err_q;
    rd_data   = rd_err ? '0 : rd_word;
  end

  apb_sram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .be    (strb_q),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prdata_d   = prdata_q;
    pready_d   = pready_q;
    pselverr_d = pselverr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (setup) begin
          addr_d  = idx[AW-1:0];
          wr_d    = bus.wr_en;
          err_d   = setup_err;
          wdata_d = bus.pwdata;
`ifdef APB_SRAM_STRB_EN
          strb_d  = bus.pstrb;
`else
          strb_d  = '1;
`endif
          if (WS_I == 0) begin
            state_d    = ST_ACCESS;
            pready_d   = 1'b1;
            pselverr_d = setup_err;
            prdata_d   = rd_data;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!bus.psel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = ST_ACCESS;
            pready_d   = 1'b1;
            pselverr_d = err_q;
            prdata_d   = rd_data;
          end
        end
      end

      ST_ACCESS: begin
        // Dropping psel aborts; psel with pen completes. Either way the outputs clear.
        if (!bus.psel || bus.pen) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          pready_d   = 1'b0;
          pselverr_d = 1'b0;
          prdata_d   = '0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        pready_d   = 1'b0;
        pselverr_d = 1'b0;
        prdata_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pselverr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pselverr_q <= pselverr_d;
    end
  end

  assign bus.prdata   = prdata_q;
  assign bus.pready   = pready_q;
  assign bus.pselverr = pselverr_q;

endmodule

// File: tb/tb_apb_sram_slave.sv
// Self-checking bench: two slaves (0 and 2 wait states) driven by a simple APB master.
// Strobe vectors are added when APB_SRAM_STRB_EN is defined.
module tb_apb_sram_slave;

  localparam int WS_A = 0;
  localparam int WS_B = 2;

  logic clk;
  logic rst;

  logic        psel_v   [2];
  logic        pen_v    [2];
  logic        wr_v     [2];
  logic [31:0] paddr_v  [2];
  logic [31:0] pwdata_v [2];
`ifdef APB_SRAM_STRB_EN
  logic [3:0]  pstrb_v  [2];
`endif

  apb_sram_slave_if if0 ();
  apb_sram_slave_if if1 ();

  assign if0.psel   = psel_v[0];
  assign if0.pen    = pen_v[0];
  assign if0.wr_en  = wr_v[0];
  assign if0.paddr  = paddr_v[0];
  assign if0.pwdata = pwdata_v[0];
  assign if1.psel   = psel_v[1];
  assign if1.pen    = pen_v[1];
  assign if1.wr_en  = wr_v[1];
  assign if1.paddr  = paddr_v[1];
  assign if1.pwdata = pwdata_v[1];
`ifdef APB_SRAM_STRB_EN
  assign if0.pstrb  = pstrb_v[0];
  assign if1.pstrb  = pstrb_v[1];
`endif

  apb_sram_slave #(.WAIT_STATES(WS_A)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  apb_sram_slave #(.WAIT_STATES(WS_B)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          dut;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          is_rd;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? if0.pready : if1.pready;
  endfunction

  function automatic logic rerr(input int d);
    return (d == 0) ? if0.pselverr : if1.pselverr;
  endfunction

  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? if0.prdata : if1.prdata;
  endfunction

  function automatic int lat(input int d);
    return ((d == 0) ? WS_A : WS_B) + 1;
  endfunction

  task automatic add_vec(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.dut = d; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One APB transfer; entered #1 after a clock edge and returns #1 after the completion edge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input string tag,
                      output logic [31:0] rdata, output logic err);
    int cyc;
    psel_v[d] = 1'b1; pen_v[d] = 1'b0; wr_v[d] = wr;
    paddr_v[d] = addr; pwdata_v[d] = wdata;
`ifdef APB_SRAM_STRB_EN
    pstrb_v[d] = strb;
`else
    if (strb == 4'hx) rdata = '0;
`endif
    @(posedge clk); #1;
    pen_v[d] = 1'b1;
    paddr_v[d] = 32'hFFFF_FFF3;
    pwdata_v[d] = ~wdata;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rdy(d) && cyc < 40);
    rdata = rdat(d);
    err   = rerr(d);
    check({tag, "_latency"}, 64'(cyc), 64'(lat(d)));
    @(posedge clk); #1;
    psel_v[d] = 1'b0; pen_v[d] = 1'b0; wr_v[d] = 1'b0;
    check({tag, "_pready_drop"}, 64'(rdy(d)), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    exp_t        e;
    int          cyc;

    for (int d = 0; d < 2; d++) begin
      psel_v[d] = 1'b0; pen_v[d] = 1'b0; wr_v[d] = 1'b0;
      paddr_v[d] = '0; pwdata_v[d] = '0;
`ifdef APB_SRAM_STRB_EN
      pstrb_v[d] = 4'hF;
`endif
    end

    // Main vectors: {dut, wr, addr, wdata, strb, expected rdata, expected err}
    add_vec(1, 1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        0);
    add_vec(1, 0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 0);
    add_vec(0, 1, 32'h0,   32'h11111111, 4'hF, 32'h0,        0);
    add_vec(0, 1, 32'h4,   32'h22222222, 4'hF, 32'h0,        0);
    add_vec(0, 0, 32'h0,   32'h0,        4'hF, 32'h11111111, 0);
    add_vec(0, 0, 32'h4,   32'h0,        4'hF, 32'h22222222, 0);
    add_vec(0, 1, 32'h400, 32'h33333333, 4'hF, 32'h0,        1);
    add_vec(0, 1, 32'h6,   32'h44444444, 4'hF, 32'h0,        1);
    add_vec(0, 0, 32'h4,   32'h0,        4'hF, 32'h22222222, 0);
    add_vec(0, 0, 32'h400, 32'h0,        4'hF, 32'h0,        1);
    add_vec(0, 0, 32'h6,   32'h0,        4'hF, 32'h0,        1);
    add_vec(0, 1, 32'h3FC, 32'h12345678, 4'hF, 32'h0,        0);
    add_vec(0, 0, 32'h3FC, 32'h0,        4'hF, 32'h12345678, 0);
    add_vec(1, 1, 32'h8,   32'hA5A5A5A5, 4'hF, 32'h0,        0);
    add_vec(1, 0, 32'h8,   32'h0,        4'hF, 32'hA5A5A5A5, 0);
    add_vec(1, 0, 32'h1,   32'h0,        4'hF, 32'h0,        1);
    add_vec(1, 1, 32'h1000, 32'h55555555, 4'hF, 32'h0,       1);
    add_vec(1, 0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 0);
`ifdef APB_SRAM_STRB_EN
    add_vec(0, 1, 32'h20,  32'hFFFFFFFF, 4'hF, 32'h0,        0);
    add_vec(0, 1, 32'h20,  32'h00000000, 4'h5, 32'h0,        0);
    add_vec(0, 0, 32'h20,  32'h0,        4'h0, 32'hFF00FF00, 0);
    add_vec(1, 1, 32'h24,  32'h12345678, 4'hF, 32'h0,        0);
    add_vec(1, 1, 32'h24,  32'hAAAAAAAA, 4'h0, 32'h0,        0);
    add_vec(1, 0, 32'h24,  32'h0,        4'h0, 32'h12345678, 0);
`endif

    rst = 1'b1;
    #2;
    check("reset_pready0",   64'(if0.pready),   64'd0);
    check("reset_pselverr0", 64'(if0.pselverr), 64'd0);
    check("reset_prdata0",   64'(if0.prdata),   64'd0);
    check("reset_pready1",   64'(if1.pready),   64'd0);
    check("reset_pselverr1", 64'(if1.pselverr), 64'd0);
    check("reset_prdata1",   64'(if1.prdata),   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      e.is_rd = !vecs[i].wr;
      e.rdata = vecs[i].exp_rdata;
      e.err   = vecs[i].exp_err;
      sb.push_back(e);
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           $sformatf("vec%0d", i), rd, er);
      e = sb.pop_front();
      check($sformatf("vec%0d_pselverr", i), 64'(er), 64'(e.err));
      if (e.is_rd) check($sformatf("vec%0d_prdata", i), 64'(rd), 64'(e.rdata));
    end

    // Abort: drop psel during WAIT of a write to 0x8; the old word must survive.
    psel_v[1] = 1'b1; pen_v[1] = 1'b0; wr_v[1] = 1'b1;
    paddr_v[1] = 32'h8; pwdata_v[1] = 32'h5A5A5A5A;
    @(posedge clk); #1;
    pen_v[1] = 1'b1;
    @(posedge clk); #1;
    psel_v[1] = 1'b0; pen_v[1] = 1'b0; wr_v[1] = 1'b0;
    @(negedge clk);
    check("abort_wait_pready_a", 64'(if1.pready), 64'd0);
    @(negedge clk);
    check("abort_wait_pready_b", 64'(if1.pready), 64'd0);
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, "abort_rd", rd, er);
    check("abort_rd_prdata",   64'(rd), 64'hA5A5A5A5);
    check("abort_rd_pselverr", 64'(er), 64'd0);

    // Reset while a write to 0x10 sits in ACCESS with pready high.
    psel_v[1] = 1'b1; pen_v[1] = 1'b0; wr_v[1] = 1'b1;
    paddr_v[1] = 32'h10; pwdata_v[1] = 32'h0BADF00D;
`ifdef APB_SRAM_STRB_EN
    pstrb_v[1] = 4'hF;
`endif
    @(posedge clk); #1;
    pen_v[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if1.pready && cyc < 40);
    check("rst_pre_pready", 64'(if1.pready), 64'd1);
    check("rst_pre_prdata", 64'(if1.prdata), 64'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("rst_mid_pready",   64'(if1.pready),   64'd0);
    check("rst_mid_pselverr", 64'(if1.pselverr), 64'd0);
    check("rst_mid_prdata",   64'(if1.prdata),   64'd0);
    @(posedge clk); #1;
    psel_v[1] = 1'b0; pen_v[1] = 1'b0; wr_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, "rst_rd", rd, er);
    check("rst_rd_prdata",   64'(rd), 64'hDEADBEEF);
    check("rst_rd_pselverr", 64'(er), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
